unidad_control_multiciclo: RTL

- Multicycle main controller for the ARM calculator datapath.
- Decodes the instruction held in the instruction register (IR) and steps through fetch, decode, execute, memory and writeback, one state per clock.
- Each state drives the datapath enables and muxes, including the 2-bit `ExtImm` select of the immediate extension unit.
- Keeps the NZCV condition flags and suppresses the writes of instructions whose condition fails.

---
 rtl/unidad_control_multiciclo.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/unidad_control_multiciclo.sv
// Multicycle main controller for the ARM calculator datapath: Moore FSM plus NZCV flag register.
// Optional macro CTRL_BL_EN enables the LINK state for BL; when undefined, Op=10 always branches without linking.
module unidad_control_multiciclo #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ExtImm,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic       LinkW
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    LINK   = 4'd9,
    BRANCH = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  state_t     state, state_next;
  logic [3:0] flags;            // {N, Z, C, V}
  logic       cond_ex;
  alu_op_t    dp_op;
  logic [3:0] cmd;
  logic       is_cmp;
  logic       is_logic;

  assign cmd      = Funct[4:1];
  assign is_cmp   = (cmd == 4'b1010);
  assign is_logic = (dp_op == ALU_AND) || (dp_op == ALU_ORR);

  always_comb begin
    unique case (cmd)
      4'b0100: dp_op = ALU_ADD;
      4'b0010: dp_op = ALU_SUB;
      4'b1010: dp_op = ALU_SUB;
      4'b0000: dp_op = ALU_AND;
      4'b1100: dp_op = ALU_ORR;
      default: dp_op = ALU_ADD;
    endcase
  end

  // Condition check against the stored flags.
  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    unique case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= FLAGS_RESET;
    end else begin
      state <= state_next;
      if ((state == EXECR || state == EXECI) && Funct[0]) begin
        flags[3:2] <= ALUFlags[3:2];
        if (!is_logic)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_next = FETCH;
    unique case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (!cond_ex)
          state_next = FETCH;
        else begin
          unique case (Op)
            2'b00: state_next = Funct[5] ? EXECI : EXECR;
            2'b01: state_next = MEMADR;
`ifdef CTRL_BL_EN
            2'b10: state_next = Funct[4] ? LINK : BRANCH;
`else
            2'b10: state_next = BRANCH;
`endif
            default: state_next = FETCH;
          endcase
        end
      end
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      MEMWB:  state_next = FETCH;
      MEMWR:  state_next = FETCH;
`ifdef CTRL_BL_EN
      LINK:   state_next = BRANCH;
`endif
      BRANCH: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Moore outputs; everything reads 0 while reset is held.
  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ExtImm     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    LinkW      = 1'b0;
    if (!reset) begin
      if (state != FETCH)
        RegSrc = {Op == 2'b01, Op == 2'b10};
      unique case (state)
        FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        DECODE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        EXECR: ALUControl = dp_op;
        EXECI: begin
          ALUSrcB    = 2'b01;
          ALUControl = dp_op;
        end
        ALUWB: begin
          RegWrite = ~is_cmp;
          PCWrite  = (Rd == 4'd15);
        end
        MEMADR: begin
          ALUSrcB    = 2'b01;
          ExtImm     = 2'b10;
          ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
        end
        MEMRD: AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
`ifdef CTRL_BL_EN
        LINK: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b11;
          ResultSrc = 2'b10;
          RegWrite  = 1'b1;
          LinkW     = 1'b1;
        end
`endif
        BRANCH: begin
          ALUSrcB   = 2'b01;
          ExtImm    = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
